// File: rtl/fib_seq_gen.sv
// Fibonacci-class sequence generator: divider tick or single-step advance, selectable seeds,
// one or two terms per advance, overflow policy. Optional macro FIB_SEQ_STEP_SYNC_EN adds step sync/edge detect.
module fib_seq_gen #(
  parameter int W        = 8,
  parameter int LED_W    = 8,
  parameter int CNT_W    = 25,
  parameter int TERMS    = 1,
  parameter int OVF_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             restart,
  input  logic [1:0]       seed_sel,
  input  logic [W-1:0]     seed_a,
  input  logic [W-1:0]     seed_b,
  output logic [W-1:0]     cur,
  output logic [W-1:0]     nxt,
  output logic [7:0]       idx,
  output logic             ovf,
  output logic             halted,
  output logic [LED_W-1:0] led,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_ONE = 1;
  localparam logic [8:0]       IDX_INC = (TERMS == 2) ? 9'd2 : 9'd1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q;
  logic             tick;
  logic             step_eff;
  logic             adv;
  logic [W-1:0]     seed_cur, seed_nxt;
  logic [W:0]       s1, s2;
  logic             carry;
  logic [W-1:0]     upd_cur, upd_nxt;
  logic [8:0]       idx_sum;
  logic [7:0]       idx_inc;
  logic [W-1:0]     cur_d, nxt_d;
  logic [7:0]       idx_d;
  logic             ovf_d;

`ifdef FIB_SEQ_STEP_SYNC_EN
  // Two-flop synchroniser, then a registered rising-edge pulse: one advance per press.
  logic sync1_q, sync2_q, prev_q, pulse_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= step;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end
  assign step_eff = pulse_q;
`else
  assign step_eff = step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_q + DIV_ONE;
  end
  assign tick = (div_q == '0);

  always_comb begin
    seed_cur = W'(1);
    seed_nxt = W'(1);
    case (seed_sel)
      2'b01: begin
        seed_cur = W'(2);
        seed_nxt = W'(1);
      end
      2'b10: begin
        seed_cur = seed_a;
        seed_nxt = seed_b;
      end
      default: begin
        seed_cur = W'(1);
        seed_nxt = W'(1);
      end
    endcase
  end

  // Only the sums that feed the new pair contribute to the carry.
  assign s1      = {1'b0, cur} + {1'b0, nxt};
  assign s2      = {1'b0, nxt} + {1'b0, s1[W-1:0]};
  assign carry   = (TERMS == 2) ? (s1[W] | s2[W]) : s1[W];
  assign upd_cur = (TERMS == 2) ? s1[W-1:0] : nxt;
  assign upd_nxt = (TERMS == 2) ? s2[W-1:0] : s1[W-1:0];
  assign idx_sum = {1'b0, idx} + IDX_INC;
  assign idx_inc = idx_sum[8] ? 8'hFF : idx_sum[7:0];

  assign adv = (state_q == ST_RUN) && ((run && tick) || step_eff);

  always_comb begin
    state_d = state_q;
    cur_d   = cur;
    nxt_d   = nxt;
    idx_d   = idx;
    ovf_d   = ovf;
    if (restart || (state_q == ST_LOAD)) begin
      cur_d   = seed_cur;
      nxt_d   = seed_nxt;
      idx_d   = 8'd0;
      ovf_d   = 1'b0;
      state_d = ST_RUN;
    end else if (adv) begin
      if (!carry) begin
        cur_d = upd_cur;
        nxt_d = upd_nxt;
        idx_d = idx_inc;
      end else if (OVF_MODE == 1) begin
        ovf_d   = 1'b1;
        state_d = ST_HALT;
      end else if (OVF_MODE == 2) begin
        cur_d = seed_cur;
        nxt_d = seed_nxt;
        idx_d = 8'd0;
        ovf_d = 1'b1;
      end else begin
        cur_d = upd_cur;
        nxt_d = upd_nxt;
        idx_d = idx_inc;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cur     <= '0;
      nxt     <= '0;
      idx     <= 8'd0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cur     <= cur_d;
      nxt     <= nxt_d;
      idx     <= idx_d;
      ovf     <= ovf_d;
    end
  end

  assign halted    = (state_q == ST_HALT);
  assign led       = ~cur[LED_W-1:0];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: three instances (wrap / halt / reload-with-two-terms) against a
// cycle model, plus hand-computed literal checkpoints.
module tb_fib_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b1;
  logic       step = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] seed_sel = 2'b00;
  logic [7:0] seed_a = 8'd7;
  logic [7:0] seed_b = 8'd9;

  logic [7:0] d_cur [3];
  logic [7:0] d_nxt [3];
  logic [7:0] d_idx [3];
  logic       d_ovf [3];
  logic       d_halt [3];
  logic [7:0] d_led [3];
  logic [1:0] d_st [3];

  int checks = 0;
  int errors = 0;

  int p_terms [3] = '{1, 1, 2};
  int p_mode  [3] = '{0, 1, 2};

  // Model state: 0 = load, 1 = run, 2 = halt
  int m_cur [3] = '{0, 0, 0};
  int m_nxt [3] = '{0, 0, 0};
  int m_idx [3] = '{0, 0, 0};
  int m_ovf [3] = '{0, 0, 0};
  int m_st  [3] = '{0, 0, 0};
  int m_div = 0;
  logic [3:0] m_sh = 4'b0;

  always #5 clk = ~clk;

  fib_seq_gen #(.W(8), .LED_W(8), .CNT_W(3), .TERMS(1), .OVF_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .restart(restart),
    .seed_sel(seed_sel), .seed_a(seed_a), .seed_b(seed_b),
    .cur(d_cur[0]), .nxt(d_nxt[0]), .idx(d_idx[0]), .ovf(d_ovf[0]),
    .halted(d_halt[0]), .led(d_led[0]), .state_dbg(d_st[0]));

  fib_seq_gen #(.W(8), .LED_W(8), .CNT_W(3), .TERMS(1), .OVF_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .restart(restart),
    .seed_sel(seed_sel), .seed_a(seed_a), .seed_b(seed_b),
    .cur(d_cur[1]), .nxt(d_nxt[1]), .idx(d_idx[1]), .ovf(d_ovf[1]),
    .halted(d_halt[1]), .led(d_led[1]), .state_dbg(d_st[1]));

  fib_seq_gen #(.W(8), .LED_W(8), .CNT_W(3), .TERMS(2), .OVF_MODE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .restart(restart),
    .seed_sel(seed_sel), .seed_a(seed_a), .seed_b(seed_b),
    .cur(d_cur[2]), .nxt(d_nxt[2]), .idx(d_idx[2]), .ovf(d_ovf[2]),
    .halted(d_halt[2]), .led(d_led[2]), .state_dbg(d_st[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seeds_of(input logic [1:0] sel, output int a, output int b);
    case (sel)
      2'b01:   begin a = 2; b = 1; end
      2'b10:   begin a = int'(seed_a); b = int'(seed_b); end
      default: begin a = 1; b = 1; end
    endcase
  endtask

  // Behavioural model: plain integer arithmetic on the sequence rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cur[k] = 0; m_nxt[k] = 0; m_idx[k] = 0; m_ovf[k] = 0; m_st[k] = 0;
      end
      m_div = 0;
      m_sh  = 4'b0;
    end else begin
      bit tk, seff;
      int sa, sb;
      tk = (m_div == 0);
      m_div = (m_div + 1) % 8;
`ifdef FIB_SEQ_STEP_SYNC_EN
      seff = m_sh[2] && !m_sh[3];
      m_sh = {m_sh[2:0], step};
`else
      seff = step;
`endif
      seeds_of(seed_sel, sa, sb);
      for (int k = 0; k < 3; k++) begin
        if (restart || m_st[k] == 0) begin
          m_cur[k] = sa; m_nxt[k] = sb; m_idx[k] = 0; m_ovf[k] = 0; m_st[k] = 1;
        end else if (m_st[k] == 1 && ((run && tk) || seff)) begin
          int s1, s2, nc, nn, inc;
          bit o;
          s1 = m_cur[k] + m_nxt[k];
          if (p_terms[k] == 1) begin
            o = s1 > 255; nc = m_nxt[k]; nn = s1 % 256; inc = 1;
          end else begin
            s2 = m_nxt[k] + (s1 % 256);
            o = (s1 > 255) || (s2 > 255); nc = s1 % 256; nn = s2 % 256; inc = 2;
          end
          if (o && p_mode[k] == 1) begin
            m_ovf[k] = 1; m_st[k] = 2;
          end else if (o && p_mode[k] == 2) begin
            m_cur[k] = sa; m_nxt[k] = sb; m_idx[k] = 0; m_ovf[k] = 1;
          end else begin
            m_cur[k] = nc; m_nxt[k] = nn;
            m_idx[k] = (m_idx[k] + inc > 255) ? 255 : m_idx[k] + inc;
            if (o) m_ovf[k] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cmp%0d_cur", k), 32'(d_cur[k]), 32'(m_cur[k]));
      check($sformatf("cmp%0d_nxt", k), 32'(d_nxt[k]), 32'(m_nxt[k]));
      check($sformatf("cmp%0d_idx", k), 32'(d_idx[k]), 32'(m_idx[k]));
      check($sformatf("cmp%0d_ovf", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
      check($sformatf("cmp%0d_halted", k), 32'(d_halt[k]), 32'(m_st[k] == 2));
      check($sformatf("cmp%0d_led", k), 32'(d_led[k]), 32'((~m_cur[k]) & 8'hFF));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    edges(1);
    check("load_cur", 32'(d_cur[0]), 1);
    check("load_nxt", 32'(d_nxt[0]), 1);
    check("load_led", 32'(d_led[0]), 32'hFE);
    edges(32);
    check("fib4_cur", 32'(d_cur[0]), 5);
    check("fib4_led", 32'(d_led[0]), 32'hFA);
    check("fib4_idx", 32'(d_idx[0]), 4);
    edges(16);
    check("reload_cur", 32'(d_cur[2]), 1);
    check("reload_idx", 32'(d_idx[2]), 0);
    check("reload_ovf", 32'(d_ovf[2]), 1);
    edges(48);
    check("wrap_cur", 32'(d_cur[0]), 233);
    check("wrap_nxt", 32'(d_nxt[0]), 121);
    check("wrap_idx", 32'(d_idx[0]), 12);
    check("wrap_ovf", 32'(d_ovf[0]), 1);
    check("halt_cur", 32'(d_cur[1]), 144);
    check("halt_nxt", 32'(d_nxt[1]), 233);
    check("halt_idx", 32'(d_idx[1]), 11);
    check("halt_flag", 32'(d_halt[1]), 1);
    edges(8);
    check("wrap2_cur", 32'(d_cur[0]), 121);
    check("wrap2_nxt", 32'(d_nxt[0]), 98);
    step = 1'b1;
    edges(1);
    step = 1'b0;
    edges(6);
    check("halt_ignores_cur", 32'(d_cur[1]), 144);
    check("halt_ignores_idx", 32'(d_idx[1]), 11);
    // restart lands on a tick edge: seeds must win
    restart = 1'b1;
    seed_sel = 2'b01;
    edges(1);
    restart = 1'b0;
    check("restart_cur", 32'(d_cur[0]), 2);
    check("restart_nxt", 32'(d_nxt[0]), 1);
    check("restart_halt", 32'(d_halt[1]), 0);
    check("restart_ovf", 32'(d_ovf[1]), 0);
    edges(24);
    check("lucas2_cur", 32'(d_cur[2]), 18);
    check("lucas2_nxt", 32'(d_nxt[2]), 29);
    check("lucas2_idx", 32'(d_idx[2]), 6);

    run = 1'b0;
    seed_sel = 2'b00;
    restart = 1'b1;
    edges(1);
    restart = 1'b0;
    step = 1'b1; edges(1); step = 1'b0;
    edges(4);
    step = 1'b1; edges(1); step = 1'b0;
    edges(5);
    check("step2_cur", 32'(d_cur[0]), 2);
    check("step2_nxt", 32'(d_nxt[0]), 3);
    step = 1'b1; edges(4); step = 1'b0;
    edges(5);
`ifdef FIB_SEQ_STEP_SYNC_EN
    check("held_cur", 32'(d_cur[0]), 3);
    check("held_idx", 32'(d_idx[0]), 3);
`else
    check("held_cur", 32'(d_cur[0]), 13);
    check("held_idx", 32'(d_idx[0]), 6);
`endif

    seed_sel = 2'b10;
    restart = 1'b1;
    edges(1);
    restart = 1'b0;
    check("custom_cur", 32'(d_cur[0]), 7);
    check("custom_nxt", 32'(d_nxt[0]), 9);

    run = 1'b1;
    seed_sel = 2'b11;
    restart = 1'b1;
    edges(1);
    restart = 1'b0;
    for (int i = 0; i < 200 && m_cur[0] != 34; i++) edges(1);
    check("reach_34", 32'(d_cur[0]), 34);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("arst%0d_cur", k), 32'(d_cur[k]), 0);
      check($sformatf("arst%0d_nxt", k), 32'(d_nxt[k]), 0);
      check($sformatf("arst%0d_led", k), 32'(d_led[k]), 32'hFF);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    edges(1);
    check("post_rst_cur", 32'(d_cur[0]), 1);
    check("post_rst_idx", 32'(d_idx[0]), 0);
    edges(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
